// File: rtl/sensor_pkg.sv
// Shared constants and helpers for the sensor debounce block.
package sensor_pkg;

   localparam int unsigned N_CH_DEFAULT = 4;

   // Channel assignment used by the crossing controller
   localparam int unsigned TRAIN_A = 0;
   localparam int unsigned TRAIN_B = 1;
   localparam int unsigned GATE_UP = 2;
   localparam int unsigned GATE_DN = 3;

   // Counter width able to hold 0..ticks
   function automatic int unsigned CNT_W(input int unsigned ticks);
      if (ticks <= 1) return 1;
      return $clog2(ticks + 1);
   endfunction

endpackage

// File: rtl/sensor_debounce_if.sv
// Slow-clock input, raw sensors and debounced outputs of the sensor debounce block.
interface sensor_debounce_if
   import sensor_pkg::*;
#(
   parameter int unsigned N_CH = N_CH_DEFAULT
);

   logic            Clk190;
   logic [N_CH-1:0] sensor_in;
   logic [N_CH-1:0] sensor_level;
   logic [N_CH-1:0] sensor_rise;
   logic [N_CH-1:0] sensor_fall;
   logic            tick;

   modport master (
      output Clk190,
      output sensor_in,
      input  sensor_level,
      input  sensor_rise,
      input  sensor_fall,
      input  tick
   );

   modport slave (
      input  Clk190,
      input  sensor_in,
      output sensor_level,
      output sensor_rise,
      output sensor_fall,
      output tick
   );

endinterface

// File: rtl/debounce_channel.sv
// One sensor channel: 2-flop synchronizer, tick-qualified counter, level and edge pulses.
module debounce_channel
   import sensor_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = 4,
   parameter bit          RESET_LEVEL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CW      = CNT_W(DEBOUNCE_TICKS);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS - 1);

   logic          sync_q;
   logic          s;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_d;
   logic          level_d;
   logic          rise_d;
   logic          fall_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= RESET_LEVEL;
         s      <= RESET_LEVEL;
         cnt    <= '0;
         level  <= RESET_LEVEL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= raw;
         s      <= sync_q;
         cnt    <= cnt_d;
         level  <= level_d;
         rise   <= rise_d;
         fall   <= fall_d;
      end
   end

   // Qualification: any sample matching the current level restarts the count
   always_comb begin
      cnt_d   = cnt;
      level_d = level;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (tick) begin
         if (s == level) begin
            cnt_d = '0;
         end else if (cnt == CNT_MAX) begin
            cnt_d   = '0;
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
         end else begin
            cnt_d = cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/sensor_debounce.sv
// Turns Clk190 rising edges into mClk strobes and debounces N_CH sensor inputs on them.
module sensor_debounce
   import sensor_pkg::*;
#(
   parameter int unsigned N_CH           = N_CH_DEFAULT,
   parameter int unsigned DEBOUNCE_TICKS = 4,
   parameter bit          RESET_LEVEL    = 1'b0
) (
   input  logic             mClk,
   input  logic             Reset,
   sensor_debounce_if.slave bus
);

   logic            clk190_q;
   logic            tick_q;
   logic [N_CH-1:0] level;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;

   // clk190_q resets high so an already-high Clk190 gives no tick at release
   always_ff @(posedge mClk or posedge Reset) begin
      if (Reset) begin
         clk190_q <= 1'b1;
         tick_q   <= 1'b0;
      end else begin
         clk190_q <= bus.Clk190;
         tick_q   <= bus.Clk190 & ~clk190_q;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .RESET_LEVEL    (RESET_LEVEL)
      ) u_ch (
         .clk   (mClk),
         .rst   (Reset),
         .tick  (tick_q),
         .raw   (bus.sensor_in[i]),
         .level (level[i]),
         .rise  (rise[i]),
         .fall  (fall[i])
      );
   end

   assign bus.tick         = tick_q;
   assign bus.sensor_level = level;
   assign bus.sensor_rise  = rise;
   assign bus.sensor_fall  = fall;

endmodule
